// File: rtl/raster_pkg.sv
// Shared types for the raster drawing engine: FSM state encoding and draw modes.
package raster_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic MODE_LINE = 1'b0;
  localparam logic MODE_RECT = 1'b1;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_stepper.sv
// Integer Bresenham line walker: load captures the endpoints, each step advances one pixel.
module line_stepper
  import raster_pkg::*;
#(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic           at_end,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  // Two guard bits keep 2*err inside the signed range for the widest possible line.
  localparam int unsigned E_W = max_w(X_W, Y_W) + 2;

  logic [X_W-1:0]        x_q, x_end_q;
  logic [Y_W-1:0]        y_q, y_end_q;
  logic signed [E_W-1:0] err_q, dx_q, dy_q;
  logic                  sx_q, sy_q;

  logic [X_W-1:0]        dx_abs;
  logic [Y_W-1:0]        dy_abs;
  logic signed [E_W-1:0] dx_c, dy_c, e2, err_d;
  logic                  move_x, move_y;

  always_comb begin
    dx_abs = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
    dy_abs = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
    dx_c   = signed'({{(E_W - X_W){1'b0}}, dx_abs});
    dy_c   = signed'({{(E_W - Y_W){1'b0}}, dy_abs});
    e2     = err_q <<< 1;
    move_x = (e2 > -dy_q);
    move_y = (e2 < dx_q);
    err_d  = err_q;
    if (move_x) err_d = err_d - dy_q;
    if (move_y) err_d = err_d + dx_q;
  end

  assign at_end = (x_q == x_end_q) && (y_q == y_end_q);
  assign x      = x_q;
  assign y      = y_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      err_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
    end else if (load) begin
      x_q     <= x0;
      y_q     <= y0;
      x_end_q <= x1;
      y_end_q <= y1;
      dx_q    <= dx_c;
      dy_q    <= dy_c;
      err_q   <= dx_c - dy_c;
      sx_q    <= (x1 < x0);
      sy_q    <= (y1 < y0);
    end else if (step && !at_end) begin
      err_q <= err_d;
      if (move_x) x_q <= sx_q ? (x_q - X_W'(1)) : (x_q + X_W'(1));
      if (move_y) y_q <= sy_q ? (y_q - Y_W'(1)) : (y_q + Y_W'(1));
    end
  end

endmodule

// File: rtl/raster_draw.sv
// Line / filled-rectangle pixel generator with a ready-stallable pixel output stream.
module raster_draw
  import raster_pkg::*;
#(
  parameter int unsigned X_W      = 9,
  parameter int unsigned Y_W      = 8,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                mode,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                pixel_ready,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                busy,
  output logic                done
);

  state_t state_q, state_d;

  logic                mode_q;
  logic [X_W-1:0]      x0_q, x1_q;
  logic [Y_W-1:0]      y0_q, y1_q;
  logic [COLOUR_W-1:0] colour_q;

  logic [X_W-1:0] rx_q, rx_min_q, rx_max_q;
  logic [Y_W-1:0] ry_q, ry_max_q;

  logic           latch, setup, accept, last, ls_step, rect_step;
  logic           ls_at_end, rect_end;
  logic [X_W-1:0] ls_x;
  logic [Y_W-1:0] ls_y;

  line_stepper #(
    .X_W(X_W),
    .Y_W(Y_W)
  ) u_line_stepper (
    .clock (clock),
    .reset (reset),
    .load  (setup),
    .step  (ls_step),
    .x0    (x0_q),
    .x1    (x1_q),
    .y0    (y0_q),
    .y1    (y1_q),
    .at_end(ls_at_end),
    .x     (ls_x),
    .y     (ls_y)
  );

  assign rect_end = (rx_q == rx_max_q) && (ry_q == ry_max_q);

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    setup     = 1'b0;
    accept    = 1'b0;
    ls_step   = 1'b0;
    rect_step = 1'b0;
    last      = (mode_q == MODE_RECT) ? rect_end : ls_at_end;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          latch   = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        setup   = 1'b1;
        state_d = DRAW;
      end
      DRAW: begin
        accept = pixel_ready;
        if (accept) begin
          if (last) begin
            state_d = FINISH;
          end else if (mode_q == MODE_RECT) begin
            rect_step = 1'b1;
          end else begin
            ls_step = 1'b1;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign plot       = (state_q == DRAW);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign x_out      = (mode_q == MODE_RECT) ? rx_q : ls_x;
  assign y_out      = (mode_q == MODE_RECT) ? ry_q : ls_y;
  assign colour_out = colour_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_LINE;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      rx_min_q <= '0;
      rx_max_q <= '0;
      ry_max_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        mode_q   <= mode;
        x0_q     <= x0;
        x1_q     <= x1;
        y0_q     <= y0;
        y1_q     <= y1;
        colour_q <= colour_in;
      end
      if (setup) begin
        rx_q     <= (x0_q < x1_q) ? x0_q : x1_q;
        rx_min_q <= (x0_q < x1_q) ? x0_q : x1_q;
        rx_max_q <= (x0_q < x1_q) ? x1_q : x0_q;
        ry_q     <= (y0_q < y1_q) ? y0_q : y1_q;
        ry_max_q <= (y0_q < y1_q) ? y1_q : y0_q;
      end else if (rect_step) begin
        // Raster order: wrap x back to the left edge at the end of each row.
        if (rx_q == rx_max_q) begin
          rx_q <= rx_min_q;
          ry_q <= ry_q + Y_W'(1);
        end else begin
          rx_q <= rx_q + X_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/raster_draw.md
RASTER_DRAW -- requirements
Module: raster_draw

Interface
REQ-001 Parameter X_W, default 9, x coordinate width.
REQ-002 Parameter Y_W, default 8, y coordinate width.
REQ-003 Parameter COLOUR_W, default 3, colour width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 go  in  1  start request; sampled only in IDLE.
REQ-008 mode  in  1  0 = line, 1 = filled rectangle.
REQ-009 x0, x1  in  X_W  unsigned endpoint/corner x.
REQ-010 y0, y1  in  Y_W  unsigned endpoint/corner y.
REQ-011 colour_in  in  COLOUR_W  draw colour.
REQ-012 pixel_ready  in  1  downstream accepts the current pixel.
REQ-013 plot  out  1  x_out/y_out/colour_out valid.
REQ-014 x_out  out  X_W; y_out  out  Y_W; colour_out  out  COLOUR_W.
REQ-015 busy  out  1  operation in progress.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, DRAW, FINISH.
REQ-018 In IDLE with go=1, the block SHALL latch mode, x0, x1, y0, y1 and colour_in, then enter SETUP.
REQ-019 go SHALL be ignored in every state other than IDLE.
REQ-020 SETUP (one cycle) SHALL compute dx=|x1-x0|, dy=|y1-y0|, the step signs and the initial error; the next state is DRAW.
REQ-021 Latency: go at cycle t gives busy=1 from t+1 and the first plot=1 at t+2.
REQ-022 In DRAW, plot SHALL be 1; a pixel is accepted on a cycle with plot=1 and pixel_ready=1.
REQ-023 While plot=1 and pixel_ready=0, x_out, y_out and colour_out SHALL hold stable.
REQ-024 Line mode SHALL use integer Bresenham in all octants:
- start at (x0,y0), end at (x1,y1) inclusive;
- err = dx - dy, e2 = 2*err;
- if e2 > -dy: err -= dy, x += sx;
- if e2 < dx: err += dx, y += sy;
- pixel count = max(dx,dy)+1.
REQ-025 The error register SHALL be signed, max(X_W,Y_W)+2 bits wide, and SHALL never overflow.
REQ-026 Rectangle mode SHALL emit every pixel from (min x, min y) to (max x, max y) inclusive:
- raster order, x fastest;
- pixel count = (dx+1)*(dy+1).
REQ-027 A degenerate request (x0=x1 and y0=y1) in either mode SHALL emit exactly one pixel.
REQ-028 Acceptance of the final pixel SHALL move the FSM to FINISH.
REQ-029 FINISH SHALL assert done=1 and plot=0 for one cycle, then return to IDLE.
REQ-030 busy SHALL be 1 in SETUP, DRAW and FINISH, and 0 in IDLE.
REQ-031 colour_out SHALL equal the latched colour, not the live colour_in.
REQ-032 go=1 in the FINISH cycle SHALL be ignored; a new request is accepted no earlier than the following IDLE cycle.
REQ-033 Changes to inputs other than go during an operation SHALL have no effect.

Reset
REQ-034 On reset=1 the FSM SHALL enter IDLE asynchronously, from any state including mid-draw.
REQ-035 During reset, plot, busy and done SHALL be 0.
REQ-036 During reset, x_out, y_out, colour_out and all internal registers SHALL be 0.
REQ-037 After reset is released, the first request SHALL be accepted on the first rising edge with go=1.

Structure
REQ-038 Shared package raster_pkg SHALL hold the FSM state enum and the MODE_LINE / MODE_RECT encodings.
REQ-039 The Bresenham datapath SHALL be a sub-module line_stepper with ports load, step, at_end, x and y.
REQ-040 Rectangle scanning and the FSM SHALL reside in raster_draw.

Verification
REQ-041 Line (0,0)->(5,2), pixel_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2); done at cycle t+8.
REQ-042 Steep negative line (3,7)->(1,0) -> 8 pixels, y decrementing each step, last pixel (1,0); all octants swept against a reference model.
REQ-043 Rectangle (4,2)->(2,3) -> 6 pixels in order (2,2),(3,2),(4,2),(2,3),(3,3),(4,3), then a single done pulse.
REQ-044 pixel_ready toggling 1/0 every cycle on line (0,0)->(3,3) -> outputs held while stalled, 4 distinct pixels, no loss or duplication.
REQ-045 Line (10,10)->(200,100) with reset=1 at the 20th pixel -> plot, busy and done 0 immediately; after release, go with (5,5)->(5,5) emits exactly one pixel.
REQ-046 Max-width line (0,0)->(511,255) -> 512 pixels, final pixel (511,255), error register never overflows.
